count_pulse_sequencer: RTL

- Generates the event stream that the two-channel event counter consumes.
- Programs a number of channel-0 events and channel-1 events. Emits them as single-cycle En pulses, with Slt selecting the channel, separated by a programmable idle gap.
- Start/Busy/Done handshake; tracks how many events it has issued so a bench or controller can predict the counter's outputs.

---
 rtl/count_pkg.sv | 23 ++
 rtl/count_gap_timer.sv | 30 +++
 rtl/count_pulse_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/count_pkg.sv
// Shared types and constants for the count pulse sequencer and its gap timer.
package count_pkg;

   localparam int WIDTH_DEF = 64;
   localparam int GAP_W_DEF = 8;

   // Channel-1 events are divided by this factor in the downstream counter.
   localparam int CH1_DIV = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE0 = 3'd1,
      ST_ISSUE1 = 3'd2,
      ST_GAP    = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   // Value the downstream channel-1 counter should settle to for a given issued count.
   function automatic logic [WIDTH_DEF-1:0] ch1_expected(input logic [WIDTH_DEF-1:0] issued);
      return issued / WIDTH_DEF'(CH1_DIV);
   endfunction

endpackage

// File: rtl/count_gap_timer.sv
// Loadable down-counter that flags the last cycle of an inter-event gap.
module count_gap_timer
   import count_pkg::*;
#(
   parameter int GAP_W = GAP_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [GAP_W-1:0] value_i,
   output logic             expire_o
);

   logic [GAP_W-1:0] cnt_q;

   // Load the gap length, then count down once per cycle until zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= value_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - GAP_W'(1);
      end
   end

   // The cycle holding a count of one is the final idle cycle of the gap.
   assign expire_o = (cnt_q == GAP_W'(1));

endmodule

// File: rtl/count_pulse_sequencer.sv
// Emits Count0 channel-0 strobes then Count1 channel-1 strobes, separated by Gap idle cycles.
module count_pulse_sequencer
   import count_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int GAP_W = GAP_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] count0_i,
   input  logic [WIDTH-1:0] count1_i,
   input  logic [GAP_W-1:0] gap_i,
   output logic             en_o,
   output logic             slt_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] issued0_o,
   output logic [WIDTH-1:0] issued1_o
);

   state_t           state_q;
   logic             en_q;
   logic             slt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] count0_q;
   logic [WIDTH-1:0] count1_q;
   logic [GAP_W-1:0] gap_q;
   logic [WIDTH-1:0] issued0_q;
   logic [WIDTH-1:0] issued1_q;

   logic more_d;
   logic next_ch1_d;
   logic in_issue_d;
   logic issue_now_d;
   logic timer_load_d;
   logic gap_expire;

   // Decide whether events remain, which channel is next, and whether one fires at this edge.
   always_comb begin
      more_d       = (issued0_q < count0_q) || (issued1_q < count1_q);
      next_ch1_d   = !(issued0_q < count0_q);
      in_issue_d   = (state_q == ST_ISSUE0) || (state_q == ST_ISSUE1);
      issue_now_d  = (in_issue_d && more_d && (gap_q == '0)) ||
                     ((state_q == ST_GAP) && gap_expire);
      timer_load_d = in_issue_d && more_d && (gap_q != '0) && !abort_i;
   end

   count_gap_timer #(
      .GAP_W (GAP_W)
   ) u_gap_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (timer_load_d),
      .value_i  (gap_q),
      .expire_o (gap_expire)
   );

   // Sequencer FSM; outputs are registered so En/Slt/Done line up with the state they belong to.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         en_q      <= 1'b0;
         slt_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         count0_q  <= '0;
         count1_q  <= '0;
         gap_q     <= '0;
         issued0_q <= '0;
         issued1_q <= '0;
      end else begin
         en_q   <= 1'b0;
         slt_q  <= 1'b0;
         done_q <= 1'b0;
         if (state_q == ST_IDLE) begin
            // Start wins over a simultaneous Abort; the first event goes out on the accepting edge.
            if (start_i) begin
               count0_q <= count0_i;
               count1_q <= count1_i;
               gap_q    <= gap_i;
               busy_q   <= 1'b1;
               if (count0_i != '0) begin
                  state_q   <= ST_ISSUE0;
                  en_q      <= 1'b1;
                  issued0_q <= WIDTH'(1);
                  issued1_q <= '0;
               end else if (count1_i != '0) begin
                  state_q   <= ST_ISSUE1;
                  en_q      <= 1'b1;
                  slt_q     <= 1'b1;
                  issued0_q <= '0;
                  issued1_q <= WIDTH'(1);
               end else begin
                  state_q   <= ST_FINISH;
                  done_q    <= 1'b1;
                  issued0_q <= '0;
                  issued1_q <= '0;
               end
            end
         end else if (abort_i) begin
            // Abort outranks any pending event and suppresses Done.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end else if (issue_now_d) begin
            en_q <= 1'b1;
            if (next_ch1_d) begin
               state_q   <= ST_ISSUE1;
               slt_q     <= 1'b1;
               issued1_q <= issued1_q + WIDTH'(1);
            end else begin
               state_q   <= ST_ISSUE0;
               issued0_q <= issued0_q + WIDTH'(1);
            end
         end else begin
            case (state_q)
               ST_ISSUE0, ST_ISSUE1: begin
                  if (!more_d) begin
                     state_q <= ST_FINISH;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_GAP;
                  end
               end
               ST_GAP: begin
                  state_q <= ST_GAP;
               end
               default: begin
                  // FINISH (or any stray encoding) returns to IDLE and releases Busy.
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign en_o      = en_q;
   assign slt_o     = slt_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign issued0_o = issued0_q;
   assign issued1_o = issued1_q;

endmodule
